// File: rtl/instr_mem_pkg.sv
// Shared types and helpers for the instruction-memory responder.
// Holds the FSM state type, word-address mapping and even-parity helper.
package instr_mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  localparam int unsigned DATA_W_DEF = 16;
  localparam int unsigned WORD_SHIFT = $clog2(DATA_W_DEF);

  // Word index of a bit address (the pc advances by DATA_W per instruction).
  function automatic int unsigned addr_to_index(input logic [31:0] addr,
                                                input int unsigned shift = WORD_SHIFT);
    return addr >> shift;
  endfunction

  // True when the address is not word aligned or falls past the last word.
  function automatic logic addr_bad(input logic [31:0] addr,
                                    input int unsigned depth,
                                    input int unsigned shift = WORD_SHIFT);
    logic [31:0] mask;
    mask = (32'd1 << shift) - 32'd1;
    return ((addr & mask) != '0) || (addr_to_index(addr, shift) >= depth);
  endfunction

  function automatic logic even_parity(input logic [63:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/instr_mem_array.sv
// Instruction word storage: synchronous write, combinational read.
// With INSTR_MEM_PARITY_EN each word carries an even-parity bit checked on read.
module instr_mem_array
  import instr_mem_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned IDX_W  = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  widx,
`ifdef INSTR_MEM_PARITY_EN
  input  logic              wpar_flip,
  output logic              rpar_err,
`endif
  input  logic [DATA_W-1:0] wdata,
  input  logic [IDX_W-1:0]  ridx,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[widx] <= wdata;
  end

  // Read is combinational so a capture on the same edge as a write sees the old word.
  assign rdata = mem[ridx];

`ifdef INSTR_MEM_PARITY_EN
  logic par_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) par_mem[widx] <= even_parity(64'(wdata)) ^ wpar_flip;
  end

  assign rpar_err = even_parity(64'(rdata)) != par_mem[ridx];
`endif

endmodule

// File: rtl/instr_mem_responder.sv
// Fetch-side instruction memory: one request at a time, fixed latency, valid/ready response.
// Optional parity column enabled by defining INSTR_MEM_PARITY_EN.
module instr_mem_responder
  import instr_mem_pkg::*;
#(
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned DEPTH   = 256,
  parameter int unsigned LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_addr,
`ifdef INSTR_MEM_PARITY_EN
  input  logic              ld_par_flip,
`endif
  input  logic [DATA_W-1:0] ld_data
);

  localparam int unsigned SHIFT = $clog2(DATA_W);
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              err_q, err_d;

  logic              req_bad, ld_bad, accept, ld_we, rd_par_err;
  logic [IDX_W-1:0]  req_idx, ld_idx;
  logic [DATA_W-1:0] rd_data;

  assign req_bad = addr_bad(32'(req_addr), DEPTH, SHIFT);
  assign ld_bad  = addr_bad(32'(ld_addr), DEPTH, SHIFT);
  assign req_idx = IDX_W'(addr_to_index(32'(req_addr), SHIFT));
  assign ld_idx  = IDX_W'(addr_to_index(32'(ld_addr), SHIFT));
  assign ld_we   = ld_en && !ld_bad;

  assign req_ready = (state_q == IDLE) && !rst;
  assign accept    = req_valid && req_ready;
  assign rsp_valid = (state_q == RESP);
  assign rsp_data  = data_q;
  assign rsp_err   = err_q;

  instr_mem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_array (
    .clk       (clk),
    .we        (ld_we),
    .widx      (ld_idx),
`ifdef INSTR_MEM_PARITY_EN
    .wpar_flip (ld_par_flip),
    .rpar_err  (rd_par_err),
`endif
    .wdata     (ld_data),
    .ridx      (req_idx),
    .rdata     (rd_data)
  );

`ifndef INSTR_MEM_PARITY_EN
  assign rd_par_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          // Parity failures keep the stored word visible; address faults return zero.
          err_d  = req_bad || rd_par_err;
          data_d = req_bad ? '0 : rd_data;
          if (LATENCY == 1) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_W'(LATENCY - 1);
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) state_d = RESP;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
          data_d  = '0;
          err_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_instr_mem_responder.sv
// Self-checking bench for instr_mem_responder: directed table, corner sequences, random fetches.
// Parity checks are compiled in when INSTR_MEM_PARITY_EN is defined.
module tb_instr_mem_responder;

  localparam int unsigned ADDR_W  = 16;
  localparam int unsigned DATA_W  = 16;
  localparam int unsigned DEPTH   = 256;
  localparam int unsigned LATENCY = 2;

  logic              clk;
  logic              rst;
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_err;
  logic              ld_en;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_data;
  logic              par_flip;

  int checks   = 0;
  int failures = 0;

  logic [15:0] model_mem [DEPTH];

  instr_mem_responder #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .DEPTH   (DEPTH),
    .LATENCY (LATENCY)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_addr    (req_addr),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_data    (rsp_data),
    .rsp_err     (rsp_err),
    .ld_en       (ld_en),
    .ld_addr     (ld_addr),
`ifdef INSTR_MEM_PARITY_EN
    .ld_par_flip (par_flip),
`endif
    .ld_data     (ld_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // A fetch address is bad if not a whole instruction or past the last instruction.
  function automatic logic m_bad(input logic [15:0] a);
    return ((int'(a) % 16) != 0) || ((int'(a) / 16) >= int'(DEPTH));
  endfunction

  function automatic void model_load(input logic [15:0] a, input logic [15:0] d);
    if (!m_bad(a)) model_mem[int'(a) / 16] = d;
  endfunction

  task automatic do_load(input logic [15:0] a, input logic [15:0] d);
    ld_en   = 1'b1;
    ld_addr = a;
    ld_data = d;
    @(posedge clk); #1;
    ld_en = 1'b0;
    model_load(a, d);
  endtask

  // ld_mode: 0 none, 1 load same word on the accept edge, 2 load same word one edge later.
  task automatic fetch(input string name, input logic [15:0] a, input int ld_mode,
                       input logic [15:0] ld_d, input int hold, input bit use_exp,
                       input logic e_err, input logic [15:0] e_data);
    logic        xe;
    logic [15:0] xd;
    int          cyc;
    if (use_exp) begin
      xe = e_err;
      xd = e_data;
    end else begin
      xe = m_bad(a);
      xd = xe ? 16'h0 : model_mem[int'(a) / 16];
    end
    chk({name, "_req_ready_idle"}, 32'(req_ready), 32'(1));
    rsp_ready = (hold == 0);
    req_valid = 1'b1;
    req_addr  = a;
    if (ld_mode == 1) begin
      ld_en = 1'b1; ld_addr = a; ld_data = ld_d;
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    if (ld_mode == 1) begin
      ld_en = 1'b0;
      model_load(a, ld_d);
    end
    if (ld_mode == 2) begin
      ld_en = 1'b1; ld_addr = a; ld_data = ld_d;
    end
    cyc = 0;
    while (!rsp_valid && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
      if (ld_en) begin
        ld_en = 1'b0;
        model_load(a, ld_d);
      end
    end
    if (ld_en) begin
      ld_en = 1'b0;
      model_load(a, ld_d);
    end
    chk({name, "_latency"}, 32'(cyc), 32'(LATENCY));
    chk({name, "_data"}, 32'(rsp_data), 32'(xd));
    chk({name, "_err"}, 32'(rsp_err), 32'(xe));
    chk({name, "_req_ready_busy"}, 32'(req_ready), 32'(0));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk({name, "_hold_valid"}, 32'(rsp_valid), 32'(1));
      chk({name, "_hold_data"}, 32'(rsp_data), 32'(xd));
      chk({name, "_hold_err"}, 32'(rsp_err), 32'(xe));
      chk({name, "_hold_req_ready"}, 32'(req_ready), 32'(0));
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk({name, "_post_valid"}, 32'(rsp_valid), 32'(0));
    chk({name, "_post_data"}, 32'({rsp_err, rsp_data}), 32'(0));
    chk({name, "_post_req_ready"}, 32'(req_ready), 32'(1));
  endtask

  typedef struct {
    logic [15:0] ld_a;
    logic [15:0] ld_d;
    logic [15:0] f_a;
    logic        e_err;
    logic [15:0] e_d;
    int          hold;
  } vec_t;

  vec_t vecs [9];

  initial begin
    int seen;
    logic [15:0] ra;

    vecs[0] = '{16'h0010, 16'h1234, 16'h0010, 1'b0, 16'h1234, 0};
    vecs[1] = '{16'h0030, 16'h5A5A, 16'h0018, 1'b1, 16'h0000, 1};
    vecs[2] = '{16'h0040, 16'hCAFE, 16'h1000, 1'b1, 16'h0000, 0};
    vecs[3] = '{16'h0FF0, 16'h7777, 16'h0FF0, 1'b0, 16'h7777, 5};
    vecs[4] = '{16'h1010, 16'h9999, 16'h1000, 1'b1, 16'h0000, 2};
    vecs[5] = '{16'h0048, 16'h1111, 16'h0040, 1'b0, 16'hCAFE, 0};
    vecs[6] = '{16'h0000, 16'hFFFF, 16'h0000, 1'b0, 16'hFFFF, 0};
    vecs[7] = '{16'h0020, 16'hAAAA, 16'h0030, 1'b0, 16'h5A5A, 3};
    vecs[8] = '{16'h0011, 16'h2222, 16'h0010, 1'b0, 16'h1234, 0};

    for (int i = 0; i < int'(DEPTH); i++) model_mem[i] = 16'h0;
    rst = 1'b1; req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b0;
    ld_en = 1'b0; ld_addr = '0; ld_data = '0; par_flip = 1'b0;

    @(posedge clk); #1;
    chk("reset_rsp_valid", 32'(rsp_valid), 32'(0));
    chk("reset_rsp_data", 32'(rsp_data), 32'(0));
    chk("reset_rsp_err", 32'(rsp_err), 32'(0));
    chk("reset_req_ready", 32'(req_ready), 32'(0));
    do_load(16'h0100, 16'h4242);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("release_req_ready", 32'(req_ready), 32'(1));

    for (int i = 0; i < 9; i++) begin
      do_load(vecs[i].ld_a, vecs[i].ld_d);
      fetch($sformatf("vec%0d", i), vecs[i].f_a, 0, 16'h0, vecs[i].hold, 1'b1,
            vecs[i].e_err, vecs[i].e_d);
    end
    fetch("load_in_reset", 16'h0100, 0, 16'h0, 0, 1'b1, 1'b0, 16'h4242);

    fetch("same_edge_old", 16'h0020, 1, 16'hBEEF, 0, 1'b1, 1'b0, 16'hAAAA);
    fetch("same_edge_new", 16'h0020, 0, 16'h0, 0, 1'b1, 1'b0, 16'hBEEF);
    fetch("inflight_old", 16'h0040, 2, 16'h3333, 1, 1'b1, 1'b0, 16'hCAFE);
    fetch("inflight_new", 16'h0040, 0, 16'h0, 0, 1'b1, 1'b0, 16'h3333);

    req_valid = 1'b1;
    req_addr  = 16'h0010;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("rst_wait_valid", 32'(rsp_valid), 32'(0));
    rst = 1'b1;
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'(0));
    chk("rst_rsp_valid", 32'(rsp_valid), 32'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (rsp_valid) seen++;
    end
    chk("rst_no_response", 32'(seen), 32'(0));
    chk("rst_req_ready_after", 32'(req_ready), 32'(1));
    fetch("rst_keep_0100", 16'h0100, 0, 16'h0, 0, 1'b0, 1'b0, 16'h0);
    fetch("rst_keep_0010", 16'h0010, 0, 16'h0, 0, 1'b0, 1'b0, 16'h0);

`ifdef INSTR_MEM_PARITY_EN
    par_flip = 1'b1;
    do_load(16'h0050, 16'h00FF);
    par_flip = 1'b0;
    fetch("parity_flip", 16'h0050, 0, 16'h0, 0, 1'b1, 1'b1, 16'h00FF);
    do_load(16'h0050, 16'h00FF);
    fetch("parity_clean", 16'h0050, 0, 16'h0, 0, 1'b1, 1'b0, 16'h00FF);
`endif

    for (int i = 0; i < int'(DEPTH); i++) do_load(16'(i * 16), 16'($urandom));
    for (int n = 0; n < 60; n++) begin
      ra = ($urandom_range(0, 3) != 0) ? 16'($urandom_range(0, DEPTH - 1) * 16)
                                       : 16'($urandom);
      if ($urandom_range(0, 9) < 2) begin
        do_load(ra, 16'($urandom));
      end else begin
        fetch($sformatf("rnd%0d", n), ra, int'($urandom_range(0, 2)), 16'($urandom),
              int'($urandom_range(0, 3)), 1'b0, 1'b0, 16'h0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
